// File: rtl/srv_icache_pkg.sv
// Shared constants and FSM encoding for the schoolRISCV direct-mapped instruction cache.
package srv_icache_pkg;
  localparam int LINE_W = 128;
  localparam int WORD_W = 32;
  localparam int OFFS_W = 4;
  localparam int WORDS  = LINE_W / WORD_W;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} icache_state_e;
endpackage

// File: rtl/srv_icache_ctrl.sv
// Refill controller: miss FSM, deferred invalidate, miss address latch and hit/miss counters.
module srv_icache_ctrl
  import srv_icache_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_req,
  input  logic [31:0]   cpu_addr,
  input  logic          hit,
  input  logic          inv,
  input  logic          ext_rsp,
  output logic          busy,
  output logic          ext_req,
  output logic          fill_we,
  output logic          inv_all,
  output logic [31:0]   miss_addr,
  output logic [31:0]   hit_cnt,
  output logic [31:0]   miss_cnt
);
  icache_state_e state, state_nxt;
  logic          inv_pend;
  logic          miss_start;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cpu_req && !hit && !inv) state_nxt = REQ;
      REQ:     state_nxt = WAIT;
      WAIT:    if (ext_rsp) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != IDLE);
    ext_req    = (state == REQ);
    fill_we    = (state == WAIT) && ext_rsp;
    miss_start = (state == IDLE) && cpu_req && !hit && !inv;
    // an inv_i landing in the completion cycle folds into the pending one
    inv_all    = ((state == IDLE) && inv) || (fill_we && (inv_pend || inv));
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      inv_pend  <= 1'b0;
      miss_addr <= '0;
      hit_cnt   <= '0;
      miss_cnt  <= '0;
    end else begin
      if (fill_we)                       inv_pend <= 1'b0;
      else if ((state != IDLE) && inv)   inv_pend <= 1'b1;
      if (miss_start)                    miss_addr <= cpu_addr;
      if ((state == IDLE) && cpu_req && hit) hit_cnt <= hit_cnt + 32'd1;
      if (state == REQ)                  miss_cnt <= miss_cnt + 32'd1;
    end
endmodule

// File: rtl/srv_icache.sv
// Direct-mapped I-cache: flop tag/data/valid arrays, combinational hit and word select.
module srv_icache
  import srv_icache_pkg::*;
#(
  parameter int NUM_LINES = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cpu_req_i,
  input  logic [31:0]        cpu_addr_i,
  output logic [31:0]        cpu_rdata_o,
  output logic               cpu_stall_o,
  input  logic               inv_i,
  output logic               ext_req_o,
  output logic [31:0]        ext_addr_o,
  input  logic               ext_rsp_i,
  input  logic [LINE_W-1:0]  ext_data_i,
  output logic [31:0]        hit_cnt_o,
  output logic [31:0]        miss_cnt_o
);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = 28 - IDX_W;

  logic [NUM_LINES-1:0]            valid;
  logic [TAG_W-1:0]                tag_arr  [NUM_LINES];
  logic [WORDS-1:0][WORD_W-1:0]    data_arr [NUM_LINES];

  logic [IDX_W-1:0] idx, fidx;
  logic [TAG_W-1:0] tag, ftag;
  logic [1:0]       word;
  logic             hit, busy, fill_we, inv_all;
  logic [31:0]      miss_addr;

  assign idx  = cpu_addr_i[OFFS_W+IDX_W-1:OFFS_W];
  assign tag  = cpu_addr_i[31:OFFS_W+IDX_W];
  assign word = cpu_addr_i[3:2];
  assign fidx = miss_addr[OFFS_W+IDX_W-1:OFFS_W];
  assign ftag = miss_addr[31:OFFS_W+IDX_W];

  assign hit         = valid[idx] && (tag_arr[idx] == tag);
  assign cpu_rdata_o = data_arr[idx][word];
  assign cpu_stall_o = busy || (cpu_req_i && !hit);
  assign ext_addr_o  = {miss_addr[31:OFFS_W], {OFFS_W{1'b0}}};

  srv_icache_ctrl u_ctrl (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu_req   (cpu_req_i),
    .cpu_addr  (cpu_addr_i),
    .hit       (hit),
    .inv       (inv_i),
    .ext_rsp   (ext_rsp_i),
    .busy      (busy),
    .ext_req   (ext_req_o),
    .fill_we   (fill_we),
    .inv_all   (inv_all),
    .miss_addr (miss_addr),
    .hit_cnt   (hit_cnt_o),
    .miss_cnt  (miss_cnt_o)
  );

  // invalidate wins over the fill, so a line refilled under inv lands invalid
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)       valid <= '0;
    else if (inv_all) valid <= '0;
    else if (fill_we) valid[fidx] <= 1'b1;

  always_ff @(posedge clk)
    if (fill_we) begin
      data_arr[fidx] <= ext_data_i;
      tag_arr[fidx]  <= ftag;
    end
endmodule

// File: tb/tb_srv_icache.sv
// Directed table-driven bench for srv_icache plus hand sequences for reset behaviour.
module tb_srv_icache;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         cpu_req_i;
  logic [31:0]  cpu_addr_i;
  logic [31:0]  cpu_rdata_o;
  logic         cpu_stall_o;
  logic         inv_i;
  logic         ext_req_o;
  logic [31:0]  ext_addr_o;
  logic         ext_rsp_i;
  logic [127:0] ext_data_i;
  logic [31:0]  hit_cnt_o;
  logic [31:0]  miss_cnt_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  srv_icache #(.NUM_LINES(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req_i(cpu_req_i), .cpu_addr_i(cpu_addr_i),
    .cpu_rdata_o(cpu_rdata_o), .cpu_stall_o(cpu_stall_o),
    .inv_i(inv_i),
    .ext_req_o(ext_req_o), .ext_addr_o(ext_addr_o),
    .ext_rsp_i(ext_rsp_i), .ext_data_i(ext_data_i),
    .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
  );

  typedef struct {
    logic         req;
    logic [31:0]  addr;
    logic         inv;
    logic         rsp;
    logic [127:0] data;
    logic         stall;
    logic         ext_req;
    logic [31:0]  ext_addr;
    logic         chk_rd;
    logic [31:0]  rdata;
    logic [31:0]  hits;
    logic [31:0]  misses;
  } row_t;

  row_t tbl[$];

  function automatic row_t mk(logic req, logic [31:0] addr, logic inv, logic rsp,
                              logic [127:0] data, logic stall, logic ext_req,
                              logic [31:0] ext_addr, logic chk_rd, logic [31:0] rdata,
                              logic [31:0] hits, logic [31:0] misses);
    row_t r;
    r.req = req; r.addr = addr; r.inv = inv; r.rsp = rsp; r.data = data;
    r.stall = stall; r.ext_req = ext_req; r.ext_addr = ext_addr;
    r.chk_rd = chk_rd; r.rdata = rdata; r.hits = hits; r.misses = misses;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  localparam logic [127:0] L100 = {32'h33, 32'h22, 32'h11, 32'h00};
  localparam logic [127:0] L200 = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
  localparam logic [127:0] L400 = {32'h43, 32'h42, 32'h41, 32'h40};
  localparam logic [127:0] L500 = {32'h53, 32'h52, 32'h51, 32'h50};
  localparam logic [127:0] L800 = {32'h83, 32'h82, 32'h81, 32'h80};
  localparam logic [127:0] LDED = {4{32'h0000DEAD}};

  initial begin
    //            req addr     inv rsp data  stall xreq xaddr    chk rdata  hit miss
    // cold miss on 0x100, response on cycle 5
    tbl.push_back(mk(1, 32'h100, 0, 0, '0,   1, 0, 32'h000, 0, 0,     0, 0));
    tbl.push_back(mk(1, 32'h100, 0, 0, '0,   1, 1, 32'h100, 0, 0,     0, 0));
    tbl.push_back(mk(1, 32'h100, 0, 0, '0,   1, 0, 32'h100, 0, 0,     0, 1));
    tbl.push_back(mk(1, 32'h100, 0, 0, '0,   1, 0, 32'h100, 0, 0,     0, 1));
    tbl.push_back(mk(1, 32'h100, 0, 0, '0,   1, 0, 32'h100, 0, 0,     0, 1));
    tbl.push_back(mk(1, 32'h100, 0, 1, L100, 1, 0, 32'h100, 0, 0,     0, 1));
    tbl.push_back(mk(1, 32'h100, 0, 0, '0,   0, 0, 32'h100, 1, 32'h00, 0, 1));
    tbl.push_back(mk(1, 32'h104, 0, 0, '0,   0, 0, 32'h100, 1, 32'h11, 1, 1));
    tbl.push_back(mk(1, 32'h108, 0, 0, '0,   0, 0, 32'h100, 1, 32'h22, 2, 1));
    tbl.push_back(mk(1, 32'h10C, 0, 0, '0,   0, 0, 32'h100, 1, 32'h33, 3, 1));
    // conflict on index 0, earliest response
    tbl.push_back(mk(1, 32'h200, 0, 0, '0,   1, 0, 32'h100, 0, 0,     4, 1));
    tbl.push_back(mk(1, 32'h200, 0, 0, '0,   1, 1, 32'h200, 0, 0,     4, 1));
    tbl.push_back(mk(1, 32'h200, 0, 1, L200, 1, 0, 32'h200, 0, 0,     4, 2));
    tbl.push_back(mk(1, 32'h200, 0, 0, '0,   0, 0, 32'h200, 1, 32'hA0, 4, 2));
    tbl.push_back(mk(1, 32'h100, 0, 0, '0,   1, 0, 32'h200, 0, 0,     5, 2));
    tbl.push_back(mk(1, 32'h100, 0, 0, '0,   1, 1, 32'h100, 0, 0,     5, 2));
    tbl.push_back(mk(1, 32'h100, 0, 1, L100, 1, 0, 32'h100, 0, 0,     5, 3));
    tbl.push_back(mk(1, 32'h10C, 0, 0, '0,   0, 0, 32'h100, 1, 32'h33, 5, 3));
    // spurious response in IDLE must not touch the array
    tbl.push_back(mk(0, 32'h000, 0, 1, LDED, 0, 0, 32'h100, 0, 0,     6, 3));
    tbl.push_back(mk(1, 32'h100, 0, 0, '0,   0, 0, 32'h100, 1, 32'h00, 6, 3));
    tbl.push_back(mk(0, 32'h000, 0, 0, '0,   0, 0, 32'h100, 0, 0,     7, 3));
    // inv with a missing fetch in IDLE: request deferred one cycle
    tbl.push_back(mk(1, 32'h400, 1, 0, '0,   1, 0, 32'h100, 0, 0,     7, 3));
    tbl.push_back(mk(1, 32'h400, 0, 0, '0,   1, 0, 32'h100, 0, 0,     7, 3));
    tbl.push_back(mk(1, 32'h400, 0, 0, '0,   1, 1, 32'h400, 0, 0,     7, 3));
    tbl.push_back(mk(1, 32'h400, 0, 1, L400, 1, 0, 32'h400, 0, 0,     7, 4));
    tbl.push_back(mk(1, 32'h404, 0, 0, '0,   0, 0, 32'h400, 1, 32'h41, 7, 4));
    // 0x100 was wiped by the IDLE invalidate; inv during WAIT for its refill
    tbl.push_back(mk(1, 32'h100, 0, 0, '0,   1, 0, 32'h400, 0, 0,     8, 4));
    tbl.push_back(mk(1, 32'h100, 0, 0, '0,   1, 1, 32'h100, 0, 0,     8, 4));
    tbl.push_back(mk(1, 32'h100, 1, 0, '0,   1, 0, 32'h100, 0, 0,     8, 5));
    tbl.push_back(mk(1, 32'h100, 0, 1, L100, 1, 0, 32'h100, 0, 0,     8, 5));
    tbl.push_back(mk(1, 32'h100, 0, 0, '0,   1, 0, 32'h100, 0, 0,     8, 5));
    tbl.push_back(mk(1, 32'h100, 0, 0, '0,   1, 1, 32'h100, 0, 0,     8, 5));
    tbl.push_back(mk(1, 32'h100, 0, 1, L100, 1, 0, 32'h100, 0, 0,     8, 6));
    tbl.push_back(mk(1, 32'h108, 0, 0, '0,   0, 0, 32'h100, 1, 32'h22, 8, 6));
    tbl.push_back(mk(0, 32'h000, 0, 0, '0,   0, 0, 32'h100, 0, 0,     9, 6));
    // inv arriving in the completion cycle itself
    tbl.push_back(mk(1, 32'h500, 0, 0, '0,   1, 0, 32'h100, 0, 0,     9, 6));
    tbl.push_back(mk(1, 32'h500, 0, 0, '0,   1, 1, 32'h500, 0, 0,     9, 6));
    tbl.push_back(mk(1, 32'h500, 1, 1, L500, 1, 0, 32'h500, 0, 0,     9, 7));
    tbl.push_back(mk(1, 32'h500, 0, 0, '0,   1, 0, 32'h500, 0, 0,     9, 7));
    tbl.push_back(mk(1, 32'h500, 0, 0, '0,   1, 1, 32'h500, 0, 0,     9, 7));
    tbl.push_back(mk(1, 32'h500, 0, 1, L500, 1, 0, 32'h500, 0, 0,     9, 8));
    tbl.push_back(mk(1, 32'h50C, 0, 0, '0,   0, 0, 32'h500, 1, 32'h53, 9, 8));

    rst_n = 1'b0; cpu_req_i = 1'b0; cpu_addr_i = '0; inv_i = 1'b0;
    ext_rsp_i = 1'b0; ext_data_i = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall_idle", {31'd0, cpu_stall_o}, 32'd0);
    cpu_req_i = 1'b1; cpu_addr_i = 32'h100;
    #1;
    chk("rst_stall_req", {31'd0, cpu_stall_o}, 32'd1);
    chk("rst_ext_req", {31'd0, ext_req_o}, 32'd0);
    chk("rst_ext_addr", ext_addr_o, 32'd0);
    chk("rst_hit_cnt", hit_cnt_o, 32'd0);
    chk("rst_miss_cnt", miss_cnt_o, 32'd0);
    cpu_req_i = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      cpu_req_i  = tbl[i].req;
      cpu_addr_i = tbl[i].addr;
      inv_i      = tbl[i].inv;
      ext_rsp_i  = tbl[i].rsp;
      ext_data_i = tbl[i].data;
      @(negedge clk);
      chk($sformatf("row%0d_stall", i), {31'd0, cpu_stall_o}, {31'd0, tbl[i].stall});
      chk($sformatf("row%0d_ext_req", i), {31'd0, ext_req_o}, {31'd0, tbl[i].ext_req});
      chk($sformatf("row%0d_ext_addr", i), ext_addr_o, tbl[i].ext_addr);
      chk($sformatf("row%0d_hit_cnt", i), hit_cnt_o, tbl[i].hits);
      chk($sformatf("row%0d_miss_cnt", i), miss_cnt_o, tbl[i].misses);
      if (tbl[i].chk_rd)
        chk($sformatf("row%0d_rdata", i), cpu_rdata_o, tbl[i].rdata);
      @(posedge clk); #1;
    end
    inv_i = 1'b0; ext_rsp_i = 1'b0; ext_data_i = '0;

    // reset while a refill for 0x800 is in WAIT
    cpu_req_i = 1'b1; cpu_addr_i = 32'h800;
    @(negedge clk);
    chk("mid_miss_stall", {31'd0, cpu_stall_o}, 32'd1);
    @(posedge clk); #1;
    chk("mid_req", {31'd0, ext_req_o}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #2;
    chk("mid_rst_ext_req", {31'd0, ext_req_o}, 32'd0);
    chk("mid_rst_ext_addr", ext_addr_o, 32'd0);
    chk("mid_rst_hit_cnt", hit_cnt_o, 32'd0);
    chk("mid_rst_miss_cnt", miss_cnt_o, 32'd0);
    chk("mid_rst_stall_req", {31'd0, cpu_stall_o}, 32'd1);
    cpu_req_i = 1'b0;
    #1;
    chk("mid_rst_stall_idle", {31'd0, cpu_stall_o}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    ext_rsp_i = 1'b1; ext_data_i = L800;
    @(negedge clk);
    chk("late_rsp_ext_req", {31'd0, ext_req_o}, 32'd0);
    chk("late_rsp_stall", {31'd0, cpu_stall_o}, 32'd0);
    @(posedge clk); #1;
    ext_rsp_i = 1'b0; ext_data_i = '0;
    cpu_req_i = 1'b1; cpu_addr_i = 32'h800;
    @(negedge clk);
    chk("post_rst_miss_stall", {31'd0, cpu_stall_o}, 32'd1);
    @(posedge clk); #1;
    chk("post_rst_req", {31'd0, ext_req_o}, 32'd1);
    chk("post_rst_miss_cnt", miss_cnt_o, 32'd0);
    @(posedge clk); #1;
    ext_rsp_i = 1'b1; ext_data_i = L800;
    @(posedge clk); #1;
    ext_rsp_i = 1'b0; ext_data_i = '0;
    cpu_addr_i = 32'h808;
    @(negedge clk);
    chk("post_rst_hit_stall", {31'd0, cpu_stall_o}, 32'd0);
    chk("post_rst_hit_rdata", cpu_rdata_o, 32'h82);
    chk("post_rst_miss_cnt2", miss_cnt_o, 32'd1);
    @(posedge clk); #1;
    cpu_req_i = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
